// File: rtl/dec_pwm_s_axi_regs.sv
// AXI4-Lite slave register file for the PWM decoder.
// Four 32-bit R/W registers selected by ADDR[3:2], byte-lane write strobes,
// one-cycle per-register write pulses toward the decode core, OKAY-only responses.
//
// state  | meaning
// W_IDLE | accepting AW and W (in any order); commits once both are present
// W_RESP | write committed, BVALID high until BREADY
// R_IDLE | accepting AR
// R_DATA | RDATA/RVALID held until RREADY
module dec_pwm_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     reg0_o,
    output logic [31:0]                     reg1_o,
    output logic [31:0]                     reg2_o,
    output logic [31:0]                     reg3_o,
    output logic [3:0]                      reg_wr_o
);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        rst_done_q;

    logic        aw_held_q, aw_held_d;
    logic [1:0]  aw_sel_q, aw_sel_d;
    logic        w_held_q, w_held_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic [3:0]  reg_wr_q, reg_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        awready, wready, bvalid, arready, rvalid;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [1:0]  commit_sel;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // State registers; reset discards any in-flight transaction.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // Handshake outputs decoded from registered state only (no VALID->READY path).
    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = rst_done_q & ~aw_held_q;
                wready  = rst_done_q & ~w_held_q;
            end
            W_RESP:  bvalid = 1'b1;
            default: ;
        endcase
        case (r_state_q)
            R_IDLE:  arready = rst_done_q;
            R_DATA:  rvalid  = 1'b1;
            default: ;
        endcase
    end

    assign aw_hs  = S_AXI_AWVALID & awready;
    assign w_hs   = S_AXI_WVALID & wready;
    assign ar_hs  = S_AXI_ARVALID & arready;
    assign commit = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);

    // A held address/data beat takes priority; otherwise use the one on the bus now.
    assign commit_sel  = aw_held_q ? aw_sel_q : S_AXI_AWADDR[3:2];
    assign commit_data = w_held_q ? w_data_q : S_AXI_WDATA;
    assign commit_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;

    // Next-state decode for both channel FSMs.
    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        case (w_state_q)
            W_IDLE:  if (commit) w_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Capture of early AW/W beats, lane-wise register update and read data load.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_sel_d  = aw_sel_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        reg_wr_d  = 4'b0000;
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_sel_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (commit) begin
            aw_held_d            = 1'b0;
            w_held_d             = 1'b0;
            reg_wr_d[commit_sel] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (commit_strb[k]) regs_d[commit_sel][8*k +: 8] = commit_data[8*k +: 8];
            end
        end
        // regs_q is the pre-edge value, so a same-edge write is not visible here.
        rdata_d = ar_hs ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;
    end

    // Datapath registers and the post-reset enable flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rst_done_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_sel_q   <= 2'b00;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            reg_wr_q   <= '0;
            rdata_q    <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            rst_done_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_sel_q   <= aw_sel_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            reg_wr_q   <= reg_wr_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign reg0_o        = regs_q[0];
    assign reg1_o        = regs_q[1];
    assign reg2_o        = regs_q[2];
    assign reg3_o        = regs_q[3];
    assign reg_wr_o      = reg_wr_q;

endmodule

// File: tb/tb_dec_pwm_s_axi_regs.sv
// Directed bench for the PWM decoder AXI4-Lite register file.
module tb_dec_pwm_s_axi_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  reg_wr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_pwm_s_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .reg_wr_o(reg_wr)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  exp_wr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_out(input logic [1:0] idx);
        case (idx)
            2'd0:    return reg0;
            2'd1:    return reg1;
            2'd2:    return reg2;
            default: return reg3;
        endcase
    endfunction

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] exp_wr);
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL write_ready_timeout: got awready=%b wready=%b expected 1", awready, wready);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("write_bvalid", 32'(bvalid), 32'd1);
        check("write_bresp", 32'(bresp), 32'd0);
        check("write_reg_wr", 32'(reg_wr), 32'(exp_wr));
        @(posedge clk);
        @(negedge clk);
        check("write_reg_wr_pulse", 32'(reg_wr), 32'd0);
        check("write_bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    // Called at a negedge; returns at a negedge after the R handshake.
    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
        int n = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL read_ready_timeout: got arready=%b expected 1", arready);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        check("read_rvalid", 32'(rvalid), 32'd1);
        check("read_rresp", 32'(rresp), 32'd0);
        check("read_rdata", rdata, exp);
        @(posedge clk);
        @(negedge clk);
        check("read_rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 4'b0001, 32'h0101FFFF};
        vecs[1] = '{4'h4, 32'hABCD0001, 4'hF, 4'b0010, 32'hABCD0001};
        vecs[2] = '{4'h8, 32'hDEAD0011, 4'hF, 4'b0100, 32'hDEAD0011};
        vecs[3] = '{4'hC, 32'hBEEF0011, 4'hF, 4'b1000, 32'hBEEF0011};
        vecs[4] = '{4'h0, 32'hFFFFFFFF, 4'hF, 4'b0001, 32'hFFFFFFFF};
        vecs[5] = '{4'h3, 32'h12345678, 4'b0101, 4'b0001, 32'hFF34FF78};

        // Reset and idle
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_ready_first", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        check("release_ready_next", 32'({awready, wready, arready}), 32'h7);

        // Table: basic writes, read back, strobes and ignored ADDR[1:0]
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_wr);
            check($sformatf("vec%0d_reg_out", i), reg_out(vecs[i].addr[3:2]), vecs[i].exp_rd);
            do_read(vecs[i].addr, vecs[i].exp_rd);
        end

        // W three cycles before AW, to reg1
        wdata = 32'h1111AAAA; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        check("wfirst_wready", 32'(wready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready_held", 32'(wready), 32'd0);
        check("wfirst_awready", 32'(awready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
        check("wfirst_reg1_old", reg1, 32'hABCD0001);
        awaddr = 4'h4; awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        check("wfirst_reg_wr", 32'(reg_wr), 32'b0010);
        check("wfirst_reg1", reg1, 32'h1111AAAA);
        @(posedge clk);
        @(negedge clk);

        // AW three cycles before W, to reg2
        awaddr = 4'h8; awvalid = 1'b1;
        check("awfirst_awready", 32'(awready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        check("awfirst_awready_held", 32'(awready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("awfirst_no_bvalid", 32'(bvalid), 32'd0);
        wdata = 32'h2222BBBB; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        check("awfirst_bvalid", 32'(bvalid), 32'd1);
        check("awfirst_reg_wr", 32'(reg_wr), 32'b0100);
        check("awfirst_reg2", reg2, 32'h2222BBBB);
        @(posedge clk);
        @(negedge clk);

        // Write response backpressure
        awaddr = 4'h8; wdata = 32'h5A5A0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        check("bp_awready", 32'(awready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", 32'(bvalid), 32'd1);
            check("bp_bresp", 32'(bresp), 32'd0);
            check("bp_ready_low", 32'({awready, wready}), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_bvalid_drop", 32'(bvalid), 32'd0);
        check("bp_ready_back", 32'({awready, wready}), 32'h3);

        // Read data backpressure
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, 32'h5A5A0000);
            check("bp_arready_low", 32'(arready), 32'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_rvalid_drop", 32'(rvalid), 32'd0);
        check("bp_arready_back", 32'(arready), 32'd1);

        // Same-edge read and write of reg3
        awaddr = 4'hC; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata_old", rdata, 32'hBEEF0011);
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_reg3_new", reg3, 32'h11112222);
        @(posedge clk);
        @(negedge clk);

        // Reset while BVALID is high
        awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("mid_bvalid_before", 32'(bvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_bvalid_drop", 32'(bvalid), 32'd0);
        check("mid_regs_zero", reg0 | reg1 | reg2 | reg3, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_bvalid", 32'(bvalid), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(i * 4);
            do_read(a, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
